// File: rtl/spdif_rx.sv
// S/PDIF biphase-mark receiver: measures pulse widths, decodes preambles and
// subframes, and pairs left/right subframes into 32-bit stereo samples.
module spdif_rx #(
  parameter int GLITCH_MAX = 3,
  parameter int T12        = 13,
  parameter int T23        = 22,
  parameter int T3MAX      = 31
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spdif_i,
  output logic [31:0] sample_o,
  output logic        sample_valid_o,
  output logic        block_start_o,
  output logic        parity_err_o,
  output logic        locked_o
);

  typedef enum logic [1:0] {HUNT, PRE, DATA} state_t;
  typedef enum logic [1:0] {P_INV, P_1UI, P_2UI, P_3UI} pulse_t;

  localparam logic [7:0] W_GLITCH = 8'(GLITCH_MAX);
  localparam logic [7:0] W_12     = 8'(T12);
  localparam logic [7:0] W_23     = 8'(T23);
  localparam logic [7:0] W_3MAX   = 8'(T3MAX);
  localparam logic [7:0] W_TMO    = 8'(T3MAX + 1);

  logic [2:0]  sync_q;
  logic [7:0]  width_q;
  logic        line_edge, timeout, pulse_evt;
  pulse_t      pulse_cls;

  state_t      state_q, state_d;
  logic [1:0]  pre_cnt_q;
  pulse_t      p2_q, p3_q;
  logic [4:0]  slot_q;
  logic        half_q, par_q;
  logic [15:0] shreg_q, left_q;
  logic        cur_y_q, cur_z_q, exp_valid_q, exp_y_q;
  logic        left_ok_q, left_z_q, good_q;

  logic        go_hunt, pre_done, pre_x, pre_y, pre_z;
  logic        bit_en, bit_val, sub_done;

  // Line polarity is irrelevant: any change of the synchronized level closes a pulse.
  assign line_edge = sync_q[2] ^ sync_q[1];
  assign timeout   = !line_edge && (width_q == W_TMO);
  assign pulse_evt = line_edge || timeout;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    pulse_cls = P_INV;
    if (line_edge) begin
      if (width_q <= W_GLITCH)    pulse_cls = P_INV;
      else if (width_q <= W_12)   pulse_cls = P_1UI;
      else if (width_q <= W_23)   pulse_cls = P_2UI;
      else if (width_q <= W_3MAX) pulse_cls = P_3UI;
      else                        pulse_cls = P_INV;
    end
  end

  always_comb begin
    state_d  = state_q;
    go_hunt  = 1'b0;
    pre_done = 1'b0;
    pre_x    = 1'b0;
    pre_y    = 1'b0;
    pre_z    = 1'b0;
    bit_en   = 1'b0;
    bit_val  = 1'b0;
    sub_done = 1'b0;
    case (state_q)
      HUNT: if (pulse_evt && pulse_cls == P_3UI) state_d = PRE;
      PRE: if (pulse_evt) begin
        if (pulse_cls == P_INV) go_hunt = 1'b1;
        else if (pre_cnt_q == 2'd0) begin
          if (pulse_cls != P_3UI) go_hunt = 1'b1;
        end else if (pre_cnt_q == 2'd3) begin
          pre_z = (p2_q == P_1UI) && (p3_q == P_1UI) && (pulse_cls == P_3UI);
          pre_x = (p2_q == P_3UI) && (p3_q == P_1UI) && (pulse_cls == P_1UI);
          pre_y = (p2_q == P_2UI) && (p3_q == P_1UI) && (pulse_cls == P_2UI);
          if (!(pre_z || pre_x || pre_y))               go_hunt = 1'b1;
          else if (exp_valid_q && (pre_y != exp_y_q))   go_hunt = 1'b1;
          else begin
            pre_done = 1'b1;
            state_d  = DATA;
          end
        end
      end
      DATA: if (pulse_evt) begin
        case (pulse_cls)
          P_2UI: begin
            if (half_q) go_hunt = 1'b1;
            else        bit_en  = 1'b1;
          end
          P_1UI: begin
            bit_en  = half_q;
            bit_val = 1'b1;
          end
          default: go_hunt = 1'b1;
        endcase
        if (bit_en && slot_q == 5'd31) begin
          sub_done = 1'b1;
          state_d  = PRE;
        end
      end
      default: go_hunt = 1'b1;
    endcase
    if (go_hunt) state_d = HUNT;
  end

  // NOTE: sequential state is written only with <= so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q         <= '0;
      width_q        <= '0;
      state_q        <= HUNT;
      pre_cnt_q      <= '0;
      p2_q           <= P_INV;
      p3_q           <= P_INV;
      slot_q         <= '0;
      half_q         <= 1'b0;
      par_q          <= 1'b0;
      shreg_q        <= '0;
      left_q         <= '0;
      cur_y_q        <= 1'b0;
      cur_z_q        <= 1'b0;
      exp_valid_q    <= 1'b0;
      exp_y_q        <= 1'b0;
      left_ok_q      <= 1'b0;
      left_z_q       <= 1'b0;
      good_q         <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      block_start_o  <= 1'b0;
      parity_err_o   <= 1'b0;
      locked_o       <= 1'b0;
    end else begin
      sync_q         <= {sync_q[1:0], spdif_i};
      if (line_edge)                width_q <= 8'd1;
      else if (width_q != 8'hFF)    width_q <= width_q + 8'd1;

      state_q        <= state_d;
      sample_valid_o <= 1'b0;
      block_start_o  <= 1'b0;
      parity_err_o   <= 1'b0;

      if (state_q == HUNT && state_d == PRE) pre_cnt_q <= 2'd1;
      if (state_q == PRE && pulse_evt && !go_hunt) begin
        pre_cnt_q <= pre_cnt_q + 2'd1;
        if (pre_cnt_q == 2'd1) p2_q <= pulse_cls;
        if (pre_cnt_q == 2'd2) p3_q <= pulse_cls;
      end
      if (pre_done) begin
        slot_q  <= 5'd4;
        half_q  <= 1'b0;
        par_q   <= 1'b0;
        cur_y_q <= pre_y;
        cur_z_q <= pre_z;
      end

      if (state_q == DATA && pulse_evt && !go_hunt) begin
        if (bit_en) begin
          half_q <= 1'b0;
          par_q  <= par_q ^ bit_val;
          slot_q <= slot_q + 5'd1;
          if (slot_q >= 5'd12 && slot_q <= 5'd27) shreg_q <= {bit_val, shreg_q[15:1]};
        end else begin
          half_q <= 1'b1;
        end
      end

      // Slot 31 is the parity bit itself, so the total is par_q ^ bit_val.
      if (sub_done) begin
        pre_cnt_q   <= 2'd0;
        exp_valid_q <= 1'b1;
        exp_y_q     <= !cur_y_q;
        if (par_q != bit_val) begin
          parity_err_o <= 1'b1;
          left_ok_q    <= 1'b0;
          good_q       <= 1'b0;
        end else begin
          good_q <= 1'b1;
          if (good_q) locked_o <= 1'b1;
          if (cur_y_q) begin
            if (left_ok_q) begin
              sample_o       <= {shreg_q, left_q};
              sample_valid_o <= 1'b1;
              block_start_o  <= left_z_q;
            end
            left_ok_q <= 1'b0;
          end else begin
            left_q    <= shreg_q;
            left_ok_q <= 1'b1;
            left_z_q  <= cur_z_q;
          end
        end
      end

      if (go_hunt) begin
        exp_valid_q <= 1'b0;
        left_ok_q   <= 1'b0;
        good_q      <= 1'b0;
        locked_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spdif_rx.sv
// Scoreboard bench for spdif_rx: directed biphase-mark frames are generated with
// known audio; a negedge monitor pops the expected sample on every sample_valid_o.
`timescale 1ns/1ps
module tb_spdif_rx;

  localparam int UI = 9;
  localparam int PZ = 0;
  localparam int PX = 1;
  localparam int PY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spdif = 1'b0;
  logic [31:0] sample;
  logic        sample_valid, block_start, parity_err, locked;

  int          checks = 0;
  int          errors = 0;
  int          par_seen = 0;
  int          par_base = 0;
  logic [32:0] sb[$];
  logic [32:0] exp_word;
  bit          jit_on = 1'b0;
  int          jit_idx = 0;
  int          jit_tab[7] = '{3, -3, 2, -2, 1, -1, 0};
  logic [27:0] bad_word;

  always #10 clk = ~clk;

  spdif_rx dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .spdif_i        (spdif),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .block_start_o  (block_start),
    .parity_err_o   (parity_err),
    .locked_o       (locked)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Slots 4..31 as a vector: audio in slots 12..27, slot 31 makes parity even.
  function automatic logic [27:0] mk(input logic [15:0] a);
    logic [27:0] d;
    d        = '0;
    d[23:8]  = a;
    d[27]    = ^d[26:0];
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w);
    spdif = ~spdif;
    idle(w);
  endtask

  task automatic ui_pulse(input int n);
    int w;
    w = n * UI;
    if (jit_on) begin
      w += jit_tab[jit_idx % 7];
      jit_idx++;
    end
    pulse(w);
  endtask

  task automatic send_sub(input int pre, input logic [27:0] d, input int nbits);
    if (pre == PZ) begin
      ui_pulse(3); ui_pulse(1); ui_pulse(1); ui_pulse(3);
    end else if (pre == PX) begin
      ui_pulse(3); ui_pulse(3); ui_pulse(1); ui_pulse(1);
    end else begin
      ui_pulse(3); ui_pulse(2); ui_pulse(1); ui_pulse(2);
    end
    for (int i = 0; i < nbits; i++) begin
      if (d[i]) begin
        ui_pulse(1); ui_pulse(1);
      end else begin
        ui_pulse(2);
      end
    end
  endtask

  task automatic send_frame(input bit z, input logic [15:0] l, input logic [15:0] r);
    sb.push_back({z, r, l});
    send_sub(z ? PZ : PX, mk(l), 28);
    send_sub(PY, mk(r), 28);
  endtask

  // A trailing preamble edge closes slot 31; the silence after it unlocks the receiver.
  task automatic end_segment(input string tag);
    ui_pulse(3);
    idle(60);
    check({tag, "_pending"}, 64'(sb.size()), 64'd0);
    check({tag, "_unlocked"}, 64'(locked), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample"}, 64'(sample), 64'd0);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_block_start"}, 64'(block_start), 64'd0);
    check({tag, "_parity_err"}, 64'(parity_err), 64'd0);
    check({tag, "_locked"}, 64'(locked), 64'd0);
  endtask

  always @(negedge clk) begin
    if (parity_err) par_seen++;
    if (sample_valid) begin
      check("sample_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        check("sample", 64'(sample), 64'(exp_word[31:0]));
        check("block_start", 64'(block_start), 64'(exp_word[32]));
        check("locked_at_sample", 64'(locked), 64'd1);
      end
    end
  end

  initial begin
    idle(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(10);

    // Ideal stream: Z frame then X frames; only the first sample flags block start.
    send_frame(1'b1, 16'h1234, 16'hABCD);
    send_frame(1'b0, 16'h1111, 16'h2222);
    send_frame(1'b0, 16'h3333, 16'h4444);
    end_segment("ideal");
    check("hold_sample", 64'(sample), 64'h44443333);

    // Slot 20 flipped in a Y subframe: one parity pulse, that frame's sample dropped.
    par_base = par_seen;
    send_sub(PZ, mk(16'h5555), 28);
    bad_word     = mk(16'hAAAA);
    bad_word[16] = ~bad_word[16];
    send_sub(PY, bad_word, 28);
    send_frame(1'b0, 16'h0F0F, 16'hF0F0);
    end_segment("parity");
    check("parity_pulses", 64'(par_seen - par_base), 64'd1);

    // Line frozen mid-subframe, then a fresh stream must relock.
    send_frame(1'b1, 16'h1357, 16'h2468);
    send_sub(PX, mk(16'h9999), 10);
    idle(40);
    check("static_unlocked", 64'(locked), 64'd0);
    send_frame(1'b1, 16'hCAFE, 16'hBEEF);
    end_segment("static");

    // Same values with the line idling high, so every level is inverted.
    spdif = 1'b1;
    idle(50);
    send_frame(1'b1, 16'h1234, 16'hABCD);
    end_segment("inverted");

    // Jittered widths, then a 2-clock glitch mid-DATA forcing a re-hunt.
    jit_on = 1'b1;
    send_frame(1'b1, 16'h0001, 16'h8000);
    send_frame(1'b0, 16'h7FFF, 16'hFFFF);
    send_sub(PX, mk(16'h1234), 6);
    pulse(2);
    pulse(2);
    idle(2);
    check("glitch_unlocked", 64'(locked), 64'd0);
    send_sub(PY, mk(16'h5555), 28);
    send_frame(1'b1, 16'h4242, 16'h2424);
    end_segment("jitter");
    jit_on = 1'b0;

    // One-cycle reset in the middle of a subframe.
    send_frame(1'b1, 16'h0BAD, 16'hF00D);
    send_sub(PX, mk(16'h1111), 14);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    idle(50);
    send_frame(1'b1, 16'h6789, 16'h4321);
    end_segment("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
